// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/
// writeback, drives datapath mux selects and write strobes, stalls on the
// shared-memory handshake and counts retired instructions.
//
// Memory handshake: mem_read / mem_write are held high for as long as the
// FSM sits in FETCH, MEMRD or MEMWR; the access completes in the cycle where
// mem_ready is 1, and the FSM leaves that state at the following edge.
module riscv_multicycle_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             pc_src,
   output logic             ir_write,
   output logic             i_or_d,
   output logic             mem_read,
   output logic             mem_write,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             mem_to_reg,
   output logic             reg_write,
   output logic             illegal,
   output logic [3:0]       state,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADDR = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWR   = 4'd4,
      S_LOADWB  = 4'd5,
      S_EXEC_R  = 4'd6,
      S_EXEC_I  = 4'd7,
      S_ALUWB   = 4'd8,
      S_BRANCH  = 4'd9,
      S_ILLEGAL = 4'd10
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             illegal_q, illegal_d;
   logic             retire;

   // Next state, retire decision and sticky illegal flag
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_FETCH:   state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_d = S_MEMADDR;
               OP_R:              state_d = S_EXEC_R;
               OP_I:              state_d = S_EXEC_I;
               OP_BRANCH:         state_d = S_BRANCH;
               default:           state_d = S_ILLEGAL;
            endcase
         end
         // opcode is stable after DECODE, so anything but load/store here
         // can only come from a corrupted IR; trap it rather than guess
         S_MEMADDR: begin
            if (opcode == OP_LOAD)       state_d = S_MEMRD;
            else if (opcode == OP_STORE) state_d = S_MEMWR;
            else                         state_d = S_ILLEGAL;
         end
         S_MEMRD:   state_d = mem_ready ? S_LOADWB : S_MEMRD;
         S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
         S_LOADWB:  state_d = S_FETCH;
         S_EXEC_R:  state_d = S_ALUWB;
         S_EXEC_I:  state_d = S_ALUWB;
         S_ALUWB:   state_d = S_FETCH;
         S_BRANCH:  state_d = S_FETCH;
         S_ILLEGAL: state_d = S_ILLEGAL;
         default:   state_d = S_FETCH;
      endcase

      retire = (state_q == S_LOADWB) || (state_q == S_ALUWB) ||
               (state_q == S_BRANCH) || ((state_q == S_MEMWR) && mem_ready);
      retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
      illegal_d = illegal_q | (state_d == S_ILLEGAL);
   end

   // State, retire counter and illegal flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         retired_q <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
      end
   end

   // Datapath controls decoded from state; strobes are masked during reset
   always_comb begin
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      ir_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE:  alu_src_b = 2'b10;
         S_MEMADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_LOADWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_EXEC_R: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
         end
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            alu_op    = 2'b10;
         end
         S_ALUWB:   reg_write = 1'b1;
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b01;
            pc_src    = 1'b1;
            pc_write  = zero;
         end
         default: ;
      endcase
      if (reset) begin
         pc_write  = 1'b0;
         ir_write  = 1'b0;
         reg_write = 1'b0;
         mem_write = 1'b0;
         mem_read  = 1'b0;
      end
   end

   assign state   = state_q;
   assign retired = retired_q;
   assign illegal = illegal_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Testbench for riscv_multicycle_ctrl: directed scenarios plus randomized
// instruction streams checked against an instruction-level reference model.
module tb_riscv_multicycle_ctrl;

   localparam int CNT_W = 32;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [6:0]       opcode = 7'b0;
   logic             zero = 1'b0;
   logic             mem_ready = 1'b0;
   logic             pc_write, pc_src, ir_write, i_or_d, mem_read, mem_write;
   logic             alu_src_a, mem_to_reg, reg_write, illegal;
   logic [1:0]       alu_src_b, alu_op;
   logic [3:0]       state;
   logic [CNT_W-1:0] retired;

   int               n_checks = 0;
   int               n_fail = 0;
   logic [CNT_W-1:0] exp_retired = '0;

   riscv_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src),
      .ir_write(ir_write), .i_or_d(i_or_d), .mem_read(mem_read),
      .mem_write(mem_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
      .illegal(illegal), .state(state), .retired(retired)
   );

   // Clock
   always #5 clk = ~clk;

   // State-only part of the output table:
   // {mem_read, mem_write, i_or_d, alu_src_a, alu_src_b, alu_op,
   //  mem_to_reg, reg_write, pc_src, illegal}
   function automatic logic [11:0] exp_static(input logic [3:0] s);
      case (s)
         4'd0:    return 12'b1_0_0_0_01_00_0_0_0_0;
         4'd1:    return 12'b0_0_0_0_10_00_0_0_0_0;
         4'd2:    return 12'b0_0_0_1_10_00_0_0_0_0;
         4'd3:    return 12'b1_0_1_0_00_00_0_0_0_0;
         4'd4:    return 12'b0_1_1_0_00_00_0_0_0_0;
         4'd5:    return 12'b0_0_0_0_00_00_1_1_0_0;
         4'd6:    return 12'b0_0_0_1_00_10_0_0_0_0;
         4'd7:    return 12'b0_0_0_1_10_10_0_0_0_0;
         4'd8:    return 12'b0_0_0_0_00_00_0_1_0_0;
         4'd9:    return 12'b0_0_0_1_00_01_0_0_1_0;
         4'd10:   return 12'b0_0_0_0_00_00_0_0_0_1;
         default: return 12'b0;
      endcase
   endfunction

   // Pulse reset for one edge, checking that strobes are masked and the
   // architectural state clears; leaves the DUT idling in FETCH.
   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b1;
      #1;
      n_checks++;
      if ({pc_write, ir_write, reg_write, mem_write, mem_read} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_strobes: got %b want 00000",
                  {pc_write, ir_write, reg_write, mem_write, mem_read});
      end
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if ({state, illegal, retired} !== {4'd0, 1'b0, {CNT_W{1'b0}}}) begin
         n_fail++;
         $display("FAIL reset_state: state=%0d illegal=%b retired=%0d want 0/0/0",
                  state, illegal, retired);
      end
      exp_retired = '0;
   endtask

   // Run one instruction from FETCH to retirement. The model is the
   // instruction's phase list with stall cycles inserted; mem_ready is
   // randomized wherever the FSM must ignore it.
   task automatic run_instr(input logic [6:0] op, input logic z,
                            input int fs, input int ms, input string tag);
      logic [3:0] exp_q[$];
      logic       mr_q[$];
      int         n_ir = 0, n_pc = 0, n_rw = 0, n_mw = 0;
      logic [13:0] got, want;
      for (int i = 0; i <= fs; i++) begin
         exp_q.push_back(4'd0); mr_q.push_back(i == fs);
      end
      exp_q.push_back(4'd1); mr_q.push_back(1'($urandom_range(0, 1)));
      case (op)
         OP_LOAD: begin
            exp_q.push_back(4'd2); mr_q.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i <= ms; i++) begin
               exp_q.push_back(4'd3); mr_q.push_back(i == ms);
            end
            exp_q.push_back(4'd5); mr_q.push_back(1'($urandom_range(0, 1)));
         end
         OP_STORE: begin
            exp_q.push_back(4'd2); mr_q.push_back(1'($urandom_range(0, 1)));
            for (int i = 0; i <= ms; i++) begin
               exp_q.push_back(4'd4); mr_q.push_back(i == ms);
            end
         end
         OP_R: begin
            exp_q.push_back(4'd6); mr_q.push_back(1'($urandom_range(0, 1)));
            exp_q.push_back(4'd8); mr_q.push_back(1'($urandom_range(0, 1)));
         end
         OP_I: begin
            exp_q.push_back(4'd7); mr_q.push_back(1'($urandom_range(0, 1)));
            exp_q.push_back(4'd8); mr_q.push_back(1'($urandom_range(0, 1)));
         end
         default: begin
            exp_q.push_back(4'd9); mr_q.push_back(1'($urandom_range(0, 1)));
         end
      endcase
      foreach (exp_q[i]) begin
         @(negedge clk);
         opcode = op;
         zero = z;
         mem_ready = mr_q[i];
         #1;
         n_checks++;
         if (state !== exp_q[i]) begin
            n_fail++;
            $display("FAIL %s state cyc%0d: got %0d want %0d", tag, i, state, exp_q[i]);
         end
         want = {exp_static(exp_q[i]),
                 (exp_q[i] == 4'd0) && mr_q[i],
                 ((exp_q[i] == 4'd0) && mr_q[i]) || ((exp_q[i] == 4'd9) && z)};
         got = {mem_read, mem_write, i_or_d, alu_src_a, alu_src_b, alu_op,
                mem_to_reg, reg_write, pc_src, illegal, ir_write, pc_write};
         n_checks++;
         if (got !== want) begin
            n_fail++;
            $display("FAIL %s outputs cyc%0d: got %b want %b", tag, i, got, want);
         end
         n_checks++;
         if (retired !== exp_retired) begin
            n_fail++;
            $display("FAIL %s retired_hold cyc%0d: got %0d want %0d", tag, i, retired, exp_retired);
         end
         n_checks++;
         if ((mem_read && mem_write) || (reg_write && pc_write)) begin
            n_fail++;
            $display("FAIL %s exclusive cyc%0d: rd=%b wr=%b rw=%b pw=%b want no overlap",
                     tag, i, mem_read, mem_write, reg_write, pc_write);
         end
         n_ir += int'(ir_write);
         n_pc += int'(pc_write);
         n_rw += int'(reg_write);
         n_mw += int'(mem_write);
      end
      exp_retired = exp_retired + 1;
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (state !== 4'd0 || retired !== exp_retired) begin
         n_fail++;
         $display("FAIL %s retire: state=%0d retired=%0d want 0/%0d", tag, state, retired, exp_retired);
      end
      n_checks++;
      if (n_ir !== 1 || n_pc !== 1 + int'(op == OP_BRANCH && z) ||
          n_rw !== int'(op == OP_LOAD || op == OP_R || op == OP_I) ||
          n_mw !== ((op == OP_STORE) ? ms + 1 : 0)) begin
         n_fail++;
         $display("FAIL %s strobe_counts: ir=%0d pc=%0d rw=%0d mw=%0d want 1/%0d/%0d/%0d",
                  tag, n_ir, n_pc, n_rw, n_mw, 1 + int'(op == OP_BRANCH && z),
                  int'(op == OP_LOAD || op == OP_R || op == OP_I),
                  (op == OP_STORE) ? ms + 1 : 0);
      end
   endtask

   task automatic test_reset();
      apply_reset();
   endtask

   task automatic test_rtype();
      run_instr(OP_R, 1'b0, 0, 0, "rtype");
   endtask

   task automatic test_load_stall();
      run_instr(OP_LOAD, 1'b0, 2, 3, "load_stall");
   endtask

   task automatic test_branch();
      run_instr(OP_BRANCH, 1'b1, 0, 0, "beq_taken");
      run_instr(OP_BRANCH, 1'b0, 0, 0, "beq_not_taken");
   endtask

   task automatic test_store();
      run_instr(OP_STORE, 1'b0, 0, 0, "store");
   endtask

   task automatic test_back_to_back();
      logic [6:0] ops[5];
      ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH};
      for (int n = 0; n < 40; n++) begin
         run_instr(ops[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3), "random");
      end
   endtask

   task automatic test_illegal();
      @(negedge clk);
      opcode = 7'b1111111;
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      n_checks++;
      if (state !== 4'd1) begin
         n_fail++;
         $display("FAIL illegal_decode: got state %0d want 1", state);
      end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         mem_ready = 1'($urandom_range(0, 1));
         zero = 1'($urandom_range(0, 1));
         #1;
         n_checks++;
         if (state !== 4'd10 || illegal !== 1'b1 ||
             {pc_write, ir_write, reg_write, mem_write, mem_read} !== 5'b0) begin
            n_fail++;
            $display("FAIL illegal_hold cyc%0d: state=%0d illegal=%b strobes=%b want 10/1/00000",
                     i, state, illegal,
                     {pc_write, ir_write, reg_write, mem_write, mem_read});
         end
      end
      apply_reset();
   endtask

   task automatic test_reset_midinstr();
      logic [3:0] walk[5];
      logic       mr[5];
      walk = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3};
      mr = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         opcode = OP_LOAD;
         mem_ready = mr[i];
         #1;
         n_checks++;
         if (state !== walk[i]) begin
            n_fail++;
            $display("FAIL midreset_walk cyc%0d: got %0d want %0d", i, state, walk[i]);
         end
      end
      @(negedge clk);
      reset = 1'b1;
      mem_ready = 1'b0;
      #1;
      n_checks++;
      if (mem_read !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_mem_read: got %b want 0", mem_read);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      n_checks++;
      if (state !== 4'd0 || retired !== {CNT_W{1'b0}}) begin
         n_fail++;
         $display("FAIL midreset_after: state=%0d retired=%0d want 0/0", state, retired);
      end
   endtask

   initial begin
      test_reset();
      test_rtype();
      test_load_stall();
      test_branch();
      test_store();
      test_back_to_back();
      test_illegal();
      test_reset_midinstr();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/riscv_multicycle_ctrl.md
Name: riscv_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RISC-V datapath.
- Sequences one instruction at a time through fetch, decode, execute, memory and writeback.
- Drives every datapath 2:1 mux select and register/memory write strobe.
- Stalls on a shared-memory ready handshake and counts retired instructions.

Parameters:
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  7  instr[6:0] from the instruction register; stable except in the cycle after ir_write
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current read or write this cycle
- pc_write  out  1  PC register load enable
- pc_src  out  1  PC mux select: 0 = ALU result, 1 = ALUOut register
- ir_write  out  1  instruction register load enable
- i_or_d  out  1  memory address mux select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- alu_src_a  out  1  ALU A mux select: 0 = PC, 1 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate, 11 unused
- alu_op  out  2  ALU op: 00 = add, 01 = sub, 10 = funct-decoded
- mem_to_reg  out  1  writeback mux select: 0 = ALUOut, 1 = MDR
- reg_write  out  1  register file write enable
- illegal  out  1  unsupported opcode trapped; sticky until reset
- state  out  4  current state encoding, for debug
- retired  out  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - Sampled at posedge while high: state <= FETCH(0), retired <= 0, illegal <= 0.
  - While reset is high, pc_write, ir_write, reg_write, mem_write and mem_read are forced to 0.
  - Reset mid-instruction abandons that instruction; retired does not increment.
- Output timing:
  - All outputs are combinational decodes of state.
  - Exceptions: ir_write and pc_write also depend on mem_ready (FETCH) or zero (BRANCH).
  - Any output not listed for a state is 0.
- State encodings and actions:
  - FETCH (0): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=0.
    - If mem_ready: ir_write=1, pc_write=1, go to DECODE.
    - Else hold in FETCH.
  - DECODE (1): alu_src_a=0, alu_src_b=10, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0000011 or 0100011 -> MEMADDR
    - 0110011 -> EXEC_R
    - 0010011 -> EXEC_I
    - 1100011 -> BRANCH
    - anything else -> ILLEGAL
  - MEMADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00.
    - opcode 0000011 -> MEMRD; 0100011 -> MEMWR.
  - MEMRD (3): mem_read=1, i_or_d=1. Hold until mem_ready, then go to LOADWB.
  - MEMWR (4): mem_write=1, i_or_d=1. Hold until mem_ready, then go to FETCH and retire.
  - LOADWB (5): reg_write=1, mem_to_reg=1 -> FETCH; retire.
  - EXEC_R (6): alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB.
  - EXEC_I (7): alu_src_a=1, alu_src_b=10, alu_op=10 -> ALUWB.
  - ALUWB (8): reg_write=1, mem_to_reg=0 -> FETCH; retire.
  - BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=1, pc_write=zero -> FETCH; retire whether taken or not.
  - ILLEGAL (10): illegal=1, all strobes 0. Remains in ILLEGAL until reset.
  - Codes 11–15: next state FETCH, all outputs 0.
- Retire counter:
  - retired increments by 1 at the clock edge that leaves LOADWB, ALUWB or BRANCH, or leaves MEMWR with mem_ready=1.
  - Wraps modulo 2^CNT_W.
- Latency with mem_ready held at 1:
  - R-type and I-type: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle.
- Exclusivity: mem_read and mem_write are never both 1. reg_write and pc_write are never both 1.

Test Plan:
- Reset, then R-type (opcode 0110011), mem_ready=1 -> states 0,1,6,8,0; ir_write and pc_write high in cycle 1 only; reg_write=1 with mem_to_reg=0 in ALUWB; retired=1.
- Load (0000011), mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> FETCH lasts 3 cycles, MEMRD lasts 4 with i_or_d=1; LOADWB has mem_to_reg=1 and reg_write=1; retired +1 exactly once.
- beq (1100011) with zero=1, then with zero=0 -> pc_write=1, pc_src=1, alu_op=01 in BRANCH the first time; pc_write=0 the second time; retired +2 in total.
- Store (0100011), mem_ready=1 -> states 0,1,2,4,0; mem_write=1 for one cycle and reg_write never asserted.
- Opcode 1111111 -> DECODE then ILLEGAL; illegal=1 and all strobes 0 for 20 cycles; a reset pulse returns state=0 with illegal=0 and retired=0.
- Reset asserted while in MEMRD with mem_ready=0 -> next state is FETCH, mem_read=0 during the reset cycle, and retired is unchanged at 0.
